// File: rtl/ped_ctrl.sv
// ped_ctrl: sequences one channel's pedestal calculator.
// Starts in full-update acquisition, locks into small-signal tracking once
// enough clean updates have been seen, and falls back to acquisition on
// drift, watchdog expiry or a software request. The calculator's inhibit is
// held around trigger activity so pedestal samples are taken only on
// quiet baseline.
//
// Handshake: ped_upd is a one-cycle strobe with no backpressure. It is
// accepted only in a cycle where the registered inhibit output is low;
// strobes seen while inhibit is high are dropped without any side effect.
module ped_ctrl #(
    parameter int ABITS   = 12,
    parameter int ACQWIN  = 4,
    parameter int HOLDOFF = 64,
    parameter int DRIFT   = 8,
    parameter int TMOBITS = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             force_acq,
    input  logic             trig,
    input  logic             ped_upd,
    input  logic [ABITS-1:0] ped_val,
    output logic             mode,
    output logic             inhibit,
    output logic             locked,
    output logic             timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam logic [15:0]        HOLD_LOAD = 16'(HOLDOFF);
    localparam logic [7:0]         ACQ_LAST  = 8'(ACQWIN - 1);
    localparam logic [ABITS:0]     DRIFT_V   = (ABITS + 1)'(DRIFT);
    // Watchdog fires on the increment that would make the counter all-ones.
    localparam logic [TMOBITS-1:0] WD_LAST   = {{(TMOBITS-1){1'b1}}, 1'b0};
    localparam logic [TMOBITS-1:0] WD_ONE    = {{(TMOBITS-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [7:0]         acq_q, acq_d;
    logic [TMOBITS-1:0] wd_q, wd_d;
    logic [15:0]        hold_q, hold_d;
    logic [ABITS-1:0]   last_q, last_d;
    logic               mode_q, mode_d;
    logic               inhibit_q, inhibit_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    logic               trig_hold;
    logic               upd_acc;
    logic               wd_expire;
    logic [ABITS:0]     pv_ext, pl_ext, ped_diff;
    logic               drift_exc;

    // Trigger holdoff: reloads while trig is high, counts down once it falls.
    assign hold_d    = trig ? HOLD_LOAD : ((hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0);
    assign trig_hold = trig | (hold_q != 16'd0);

    assign upd_acc   = ped_upd & ~inhibit_q;
    assign wd_expire = (state_q != ST_IDLE) & ~inhibit_q & (wd_q == WD_LAST);

    // Absolute step computed one bit wider so the subtraction never wraps.
    assign pv_ext    = {1'b0, ped_val};
    assign pl_ext    = {1'b0, last_q};
    assign ped_diff  = (pv_ext >= pl_ext) ? (pv_ext - pl_ext) : (pl_ext - pv_ext);
    assign drift_exc = (ped_diff > DRIFT_V);

    // Next-state and registered-output logic, priority ordered.
    always_comb begin
        state_d   = state_q;
        acq_d     = acq_q;
        wd_d      = wd_q;
        last_d    = last_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acq_d = 8'd0;
                wd_d  = '0;
                if (enable) begin
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ, ST_TRACK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    acq_d   = 8'd0;
                    wd_d    = '0;
                end else if (force_acq) begin
                    state_d = ST_ACQ;
                    acq_d   = 8'd0;
                    wd_d    = '0;
                end else if (wd_expire) begin
                    state_d   = ST_ACQ;
                    acq_d     = 8'd0;
                    wd_d      = '0;
                    timeout_d = 1'b1;
                end else if (upd_acc) begin
                    wd_d = '0;
                    if (state_q == ST_ACQ) begin
                        acq_d = acq_q + 8'd1;
                        if (acq_q == ACQ_LAST) begin
                            state_d = ST_TRACK;
                            last_d  = ped_val;
                        end
                    end else if (drift_exc) begin
                        state_d = ST_ACQ;
                        acq_d   = 8'd0;
                    end else begin
                        last_d = ped_val;
                    end
                end else if (!inhibit_q) begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acq_d   = 8'd0;
                wd_d    = '0;
            end
        endcase

        mode_d    = (state_d == ST_TRACK);
        locked_d  = (state_d == ST_TRACK);
        inhibit_d = (state_d == ST_IDLE) | trig_hold;
    end

    // State, counters and outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            acq_q     <= 8'd0;
            wd_q      <= '0;
            hold_q    <= 16'd0;
            last_q    <= '0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b1;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acq_q     <= acq_d;
            wd_q      <= wd_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign mode    = mode_q;
    assign inhibit = inhibit_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ped_ctrl.sv
// tb_ped_ctrl: directed walk through the channel's life cycle followed by a
// randomized run, every cycle compared against a cycle-level behavioural
// model of the pedestal sequencing rules.
module tb_ped_ctrl;

    localparam int ABITS   = 12;
    localparam int ACQWIN  = 4;
    localparam int HOLDOFF = 64;
    localparam int DRIFT   = 8;
    localparam int TMOBITS = 6;
    localparam int WD_MAX  = (1 << TMOBITS) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             force_acq = 1'b0;
    logic             trig = 1'b0;
    logic             ped_upd = 1'b0;
    logic [ABITS-1:0] ped_val = '0;
    logic             mode, inhibit, locked, timeout;
    logic [1:0]       state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (plain integers, event-time based holdoff)
    int m_state = 0;
    int m_acq   = 0;
    int m_wd    = 0;
    int m_last  = 0;
    int cyc     = 0;
    int last_trig = 0;
    bit trig_seen = 0;
    bit m_inh = 1;
    bit m_tmo = 0;

    ped_ctrl #(
        .ABITS(ABITS), .ACQWIN(ACQWIN), .HOLDOFF(HOLDOFF),
        .DRIFT(DRIFT), .TMOBITS(TMOBITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .force_acq(force_acq),
        .trig(trig), .ped_upd(ped_upd), .ped_val(ped_val),
        .mode(mode), .inhibit(inhibit), .locked(locked),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
            $error("compare error on %s", tag);
        end
    endtask

    // One clock edge of the reference model, using the inputs the DUT sees.
    task automatic model_edge();
        bit acc, tmo, th;
        int nxt, d;
        if (!reset_n) begin
            m_state = 0; m_acq = 0; m_wd = 0; m_last = 0;
            m_inh = 1; m_tmo = 0; trig_seen = 0;
        end else begin
            acc = ped_upd && !m_inh;
            tmo = 0;
            nxt = m_state;
            if (trig) begin
                trig_seen = 1;
                last_trig = cyc;
            end
            // Held through HOLDOFF edges after the last edge that saw trig high.
            th = trig || (trig_seen && (cyc - last_trig) <= HOLDOFF);
            if (m_state == 0) begin
                if (enable) nxt = 1;
                m_acq = 0; m_wd = 0;
            end else if (!enable) begin
                nxt = 0; m_acq = 0; m_wd = 0;
            end else if (force_acq) begin
                nxt = 1; m_acq = 0; m_wd = 0;
            end else if (!m_inh && m_wd + 1 == WD_MAX) begin
                nxt = 1; tmo = 1; m_acq = 0; m_wd = 0;
            end else if (acc) begin
                m_wd = 0;
                if (m_state == 1) begin
                    m_acq = m_acq + 1;
                    if (m_acq == ACQWIN) begin
                        nxt = 2;
                        m_last = int'(ped_val);
                    end
                end else begin
                    d = int'(ped_val) - m_last;
                    if (d < 0) d = -d;
                    if (d > DRIFT) begin
                        nxt = 1; m_acq = 0;
                    end else begin
                        m_last = int'(ped_val);
                    end
                end
            end else if (!m_inh) begin
                m_wd = m_wd + 1;
            end
            m_state = nxt;
            m_tmo = tmo;
            m_inh = (nxt == 0) || th;
        end
        cyc++;
    endtask

    // Drive inputs, take one edge, then compare all outputs to the model.
    task automatic step(input logic en, input logic fa, input logic tr,
                        input logic up, input logic [ABITS-1:0] v);
        enable = en; force_acq = fa; trig = tr; ped_upd = up; ped_val = v;
        @(posedge clk);
        model_edge();
        #1;
        check("state",   32'(state),   32'(m_state));
        check("mode",    32'(mode),    32'(m_state == 2));
        check("locked",  32'(locked),  32'(m_state == 2));
        check("inhibit", 32'(inhibit), 32'(m_inh));
        check("timeout", 32'(timeout), 32'(m_tmo));
    endtask

    initial begin : main
        int pulses, pulse_at, burst;
        logic en_r, fa_r, tr_r, up_r;
        logic [ABITS-1:0] v_r;

        // 1: reset, then idle with enable low
        reset_n = 1'b0;
        repeat (4) step(0, 0, 0, 0, 12'h000);
        reset_n = 1'b1;
        repeat (10) step(0, 0, 0, 0, 12'h000);
        check("tp1_state", 32'(state), 32'd0);
        check("tp1_inhibit", 32'(inhibit), 32'd1);

        // 2: acquire with four clean updates
        step(1, 0, 0, 0, 12'h200);
        check("tp2_acq", 32'(state), 32'd1);
        repeat (3) step(1, 0, 0, 1, 12'h200);
        check("tp2_still_acq", 32'(state), 32'd1);
        step(1, 0, 0, 1, 12'h200);
        check("tp2_track", 32'(state), 32'd2);
        check("tp2_mode", 32'(mode), 32'd1);
        check("tp2_locked", 32'(locked), 32'd1);

        // 3: step of 8 tolerated, step of 9 forces re-acquire
        step(1, 0, 0, 1, 12'h208);
        check("tp3_d8", 32'(state), 32'd2);
        step(1, 0, 0, 1, 12'h211);
        check("tp3_d9", 32'(state), 32'd1);
        check("tp3_locked", 32'(locked), 32'd0);
        check("tp3_mode", 32'(mode), 32'd0);

        // 4: trigger burst and holdoff window, strobe inside is ignored
        step(1, 0, 1, 0, 12'h200);
        check("tp4_inh_rise", 32'(inhibit), 32'd1);
        repeat (9) step(1, 0, 1, 0, 12'h200);
        for (int k = 1; k <= HOLDOFF + 1; k++) begin
            step(1, 0, 0, (k == 30), 12'h200);
            if (k == HOLDOFF) check("tp4_inh_held", 32'(inhibit), 32'd1);
        end
        check("tp4_inh_rel", 32'(inhibit), 32'd0);
        repeat (3) step(1, 0, 0, 1, 12'h200);
        check("tp4_no_adv", 32'(state), 32'd1);
        step(1, 0, 0, 1, 12'h200);
        check("tp4_track", 32'(state), 32'd2);

        // 5: watchdog expiry in TRACK, then no expiry under held trigger
        pulses = 0; pulse_at = 0;
        for (int i = 1; i <= 70; i++) begin
            step(1, 0, 0, 0, 12'h200);
            if (timeout === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
        end
        check("tp5_pulses", 32'(pulses), 32'd1);
        check("tp5_pulse_at", 32'(pulse_at), 32'(WD_MAX));
        check("tp5_acq", 32'(state), 32'd1);
        repeat (4) step(1, 0, 0, 1, 12'h200);
        check("tp5_track", 32'(state), 32'd2);
        pulses = 0;
        repeat (100) begin
            step(1, 0, 1, 0, 12'h200);
            if (timeout === 1'b1) pulses++;
        end
        check("tp5_trig_no_tmo", 32'(pulses), 32'd0);
        check("tp5_trig_track", 32'(state), 32'd2);

        // 6: disable wins over force_acq; force_acq ignored in IDLE
        step(0, 1, 0, 0, 12'h200);
        check("tp6_idle", 32'(state), 32'd0);
        check("tp6_inhibit", 32'(inhibit), 32'd1);
        step(0, 1, 0, 0, 12'h200);
        check("tp6_idle_fa", 32'(state), 32'd0);

        // Randomized run against the model
        burst = 0;
        for (int n = 0; n < 2500; n++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            en_r = ($urandom_range(0, 59) != 0);
            fa_r = ($urandom_range(0, 149) == 0);
            if (burst > 0) begin
                tr_r = 1'b1;
                burst--;
            end else begin
                tr_r = 1'b0;
                if ($urandom_range(0, 119) == 0) burst = $urandom_range(1, 12);
            end
            up_r = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0)
                v_r = 12'($urandom_range(0, 4095));
            else
                v_r = 12'(12'h300 + $urandom_range(0, 14));
            step(en_r, fa_r, tr_r, up_r, v_r);
        end
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
